control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// control_unit: INIT/RUN/HALT/FAULT sequencer plus zero-latency decode for a
// single-cycle datapath. Optional call-stack guard: CONTROL_UNIT_STACK_GUARD_EN.
// Ports: clk, reset (sync, active-high), opcode[15:0] (INST[31:16]), z, carry,
//   resume -> s_inc, s_inm, we3, wez, push, pop, op_alu[2:0], pc_hold,
//   halted, fault.
module control_unit #(
    parameter int STACK_DEPTH = 16,
    parameter int DEPTH_W     = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] opcode,
    input  logic        z,
    input  logic        carry,
    input  logic        resume,
    output logic        s_inc,
    output logic        s_inm,
    output logic        we3,
    output logic        wez,
    output logic        push,
    output logic        pop,
    output logic [2:0]  op_alu,
    output logic        pc_hold,
    output logic        halted,
    output logic        fault
);

    // The depth counter must reach STACK_DEPTH itself, not just STACK_DEPTH-1.
    if (DEPTH_W < $clog2(STACK_DEPTH + 1)) begin : g_bad_depth_w
        $error("DEPTH_W too narrow for STACK_DEPTH");
    end

    typedef enum logic [1:0] {
        INIT,
        RUN,
        HALT,
        FAULT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cls;

    assign cls = opcode[15:12];

`ifdef CONTROL_UNIT_STACK_GUARD_EN
    logic [DEPTH_W-1:0] depth;
    logic [DEPTH_W-1:0] depth_nxt;
    logic               stack_full;
    logic               stack_empty;

    assign stack_full  = (depth == DEPTH_W'(STACK_DEPTH));
    assign stack_empty = (depth == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            depth <= '0;
        end else begin
            state <= state_nxt;
            depth <= depth_nxt;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        s_inc     = 1'b1;
        s_inm     = 1'b0;
        we3       = 1'b0;
        wez       = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        op_alu    = 3'b000;
        pc_hold   = 1'b0;
`ifdef CONTROL_UNIT_STACK_GUARD_EN
        depth_nxt = depth;
`endif
        unique case (state)
            INIT: begin
                pc_hold   = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                case (cls)
                    4'h1: begin
                        we3    = 1'b1;
                        wez    = 1'b1;
                        op_alu = opcode[11:9];
                    end
                    4'h2: begin
                        we3   = 1'b1;
                        s_inm = 1'b1;
                    end
                    4'h3: s_inc = 1'b0;
                    4'h4: s_inc = ~z;
                    4'h5: s_inc = z;
                    4'h6: s_inc = ~carry;
                    4'h7: begin
`ifdef CONTROL_UNIT_STACK_GUARD_EN
                        // Overflowing call: freeze the PC and trap.
                        if (stack_full) begin
                            pc_hold   = 1'b1;
                            state_nxt = FAULT;
                        end else begin
                            push      = 1'b1;
                            s_inc     = 1'b0;
                            depth_nxt = depth + DEPTH_W'(1);
                        end
`else
                        push  = 1'b1;
                        s_inc = 1'b0;
`endif
                    end
                    4'h8: begin
`ifdef CONTROL_UNIT_STACK_GUARD_EN
                        if (stack_empty) begin
                            pc_hold   = 1'b1;
                            state_nxt = FAULT;
                        end else begin
                            pop       = 1'b1;
                            depth_nxt = depth - DEPTH_W'(1);
                        end
`else
                        pop = 1'b1;
`endif
                    end
                    4'h9: state_nxt = HALT;
                    default: ;
                endcase
            end
            HALT: begin
                pc_hold = 1'b1;
                if (resume) begin
                    state_nxt = RUN;
                end
            end
            FAULT: begin
                pc_hold = 1'b1;
            end
        endcase
    end

    assign halted = (state == HALT);

`ifdef CONTROL_UNIT_STACK_GUARD_EN
    assign fault = (state == FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule
